// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX register with capture-time WB bypass, EX/MEM and MEM/WB
// operand forwarding, load-use bubble insertion, flush and global hold.
`default_nettype none

module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RW-1:0]   id_rs1,
  input  logic [RW-1:0]   id_rs2,
  input  logic [RW-1:0]   id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alu_src,
  input  logic [2:0]      id_alu_ctrl,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            flush,
  input  logic            hold,
  input  logic [RW-1:0]   mem_rd,
  input  logic            mem_reg_write,
  input  logic [XLEN-1:0] mem_result,
  input  logic [RW-1:0]   wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_srcA,
  output logic [XLEN-1:0] ex_srcB,
  output logic [2:0]      ex_alu_ctrl,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [RW-1:0]   ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write
);

  logic            valid;
  logic [XLEN-1:0] pc;
  logic [RW-1:0]   rs1;
  logic [RW-1:0]   rs2;
  logic [RW-1:0]   rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm;
  logic            alu_src;
  logic [2:0]      alu_ctrl;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;

  logic            rs2_used;
  logic            hazard;
  logic            wb_hit_id1;
  logic            wb_hit_id2;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // A load in EX whose destination feeds the decode slot cannot be forwarded in time.
  assign rs2_used = !id_alu_src || id_mem_write;
  assign hazard   = valid && mem_read && (rd != '0) && id_valid &&
                    ((rd == id_rs1) || ((rd == id_rs2) && rs2_used));
  assign id_ready = !hold && !hazard;

  assign wb_hit_id1 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1);
  assign wb_hit_id2 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      pc        <= '0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      rs1_data  <= '0;
      rs2_data  <= '0;
      imm       <= '0;
      alu_src   <= 1'b0;
      alu_ctrl  <= 3'b000;
      reg_write <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else if (!hold) begin
      if (flush || hazard) begin
        valid     <= 1'b0;
        alu_ctrl  <= 3'b000;
        reg_write <= 1'b0;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
      end else begin
        valid     <= id_valid;
        pc        <= id_pc;
        rs1       <= id_rs1;
        rs2       <= id_rs2;
        rd        <= id_rd;
        rs1_data  <= wb_hit_id1 ? wb_result : id_rs1_data;
        rs2_data  <= wb_hit_id2 ? wb_result : id_rs2_data;
        imm       <= id_imm;
        alu_src   <= id_alu_src;
        alu_ctrl  <= id_valid ? id_alu_ctrl : 3'b000;
        reg_write <= id_reg_write & id_valid;
        mem_read  <= id_mem_read  & id_valid;
        mem_write <= id_mem_write & id_valid;
      end
    end
  end

  // EX/MEM is the younger producer, so it outranks MEM/WB.
  assign fwd_rs1 = (mem_reg_write && (mem_rd != '0) && (mem_rd == rs1)) ? mem_result :
                   (wb_reg_write  && (wb_rd  != '0) && (wb_rd  == rs1)) ? wb_result  :
                   rs1_data;
  assign fwd_rs2 = (mem_reg_write && (mem_rd != '0) && (mem_rd == rs2)) ? mem_result :
                   (wb_reg_write  && (wb_rd  != '0) && (wb_rd  == rs2)) ? wb_result  :
                   rs2_data;

  assign ex_valid      = valid;
  assign ex_srcA       = fwd_rs1;
  assign ex_srcB       = alu_src ? imm : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_alu_ctrl   = valid ? alu_ctrl : 3'b000;
  assign ex_pc         = pc;
  assign ex_rd         = rd;
  assign ex_reg_write  = valid & reg_write;
  assign ex_mem_read   = valid & mem_read;
  assign ex_mem_write  = valid & mem_write;

endmodule

`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed vectors against a behavioural pipeline-register model,
// plus hand-computed literal expectations.
`default_nettype none

module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_alu_src;
  logic [2:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        flush, hold;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_reg_write, wb_reg_write;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid;
  logic [31:0] ex_srcA, ex_srcB, ex_store_data, ex_pc;
  logic [2:0]  ex_alu_ctrl;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int vectors = 0;
  int miscompares = 0;

  ex_operand_stage #(.XLEN(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_alu_src(id_alu_src), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush), .hold(hold),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_srcA(ex_srcA), .ex_srcB(ex_srcB),
    .ex_alu_ctrl(ex_alu_ctrl), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write)
  );

  always #5 clk = ~clk;

  // Model of the instruction sitting in EX.
  logic        m_valid, m_src, m_rw, m_mr, m_mw;
  logic [31:0] m_pc, m_d1, m_d2, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [2:0]  m_ctrl;

  function automatic logic [31:0] value_of(input logic [4:0] r, input logic [31:0] d);
    if (mem_reg_write && r != 0 && mem_rd == r) return mem_result;
    if (wb_reg_write && r != 0 && wb_rd == r) return wb_result;
    return d;
  endfunction

  function automatic logic model_hazard();
    logic uses_rs2;
    uses_rs2 = !id_alu_src || id_mem_write;
    return m_valid && m_mr && m_rd != 0 && id_valid &&
           (m_rd == id_rs1 || (m_rd == id_rs2 && uses_rs2));
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] a, b;
    a = value_of(m_rs1, m_d1);
    b = value_of(m_rs2, m_d2);
    cmp("id_ready", {31'b0, id_ready}, {31'b0, !hold && !model_hazard()});
    cmp("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
    cmp("ex_srcA", ex_srcA, a);
    cmp("ex_srcB", ex_srcB, m_src ? m_imm : b);
    cmp("ex_store_data", ex_store_data, b);
    cmp("ex_alu_ctrl", {29'b0, ex_alu_ctrl}, {29'b0, m_valid ? m_ctrl : 3'b000});
    cmp("ex_pc", ex_pc, m_pc);
    cmp("ex_rd", {27'b0, ex_rd}, {27'b0, m_rd});
    cmp("ex_ctl", {29'b0, ex_reg_write, ex_mem_read, ex_mem_write},
        {29'b0, m_valid & m_rw, m_valid & m_mr, m_valid & m_mw});
  endtask

  task automatic model_step();
    if (!rst_n) begin
      {m_valid, m_src, m_rw, m_mr, m_mw} = '0;
      {m_pc, m_d1, m_d2, m_imm} = '0;
      {m_rs1, m_rs2, m_rd} = '0;
      m_ctrl = 3'b000;
    end else if (hold) begin
      // frozen
    end else if (flush || model_hazard()) begin
      m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_ctrl = 3'b000;
    end else begin
      m_valid = id_valid;
      m_pc = id_pc; m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd;
      m_d1 = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs1) ? wb_result : id_rs1_data;
      m_d2 = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs2) ? wb_result : id_rs2_data;
      m_imm = id_imm; m_src = id_alu_src;
      m_ctrl = id_valid ? id_alu_ctrl : 3'b000;
      m_rw = id_reg_write & id_valid;
      m_mr = id_mem_read & id_valid;
      m_mw = id_mem_write & id_valid;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] s1, input logic [31:0] d1,
                        input logic [4:0] s2, input logic [31:0] d2, input logic [4:0] dst,
                        input logic [31:0] im, input logic src, input logic [2:0] op,
                        input logic rw, input logic mr, input logic mw);
    id_valid = v; id_rs1 = s1; id_rs1_data = d1; id_rs2 = s2; id_rs2_data = d2;
    id_rd = dst; id_imm = im; id_alu_src = src; id_alu_ctrl = op;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    id_pc = id_pc + 32'd4;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; hold = 0; flush = 0;
    id_valid = 1; id_pc = $urandom; id_rs1 = 5'($urandom); id_rs2 = 5'($urandom);
    id_rd = 5'($urandom); id_rs1_data = $urandom; id_rs2_data = $urandom;
    id_imm = $urandom; id_alu_src = 1'($urandom); id_alu_ctrl = 3'($urandom);
    id_reg_write = 1; id_mem_read = 1; id_mem_write = 1;
    mem_rd = 0; mem_reg_write = 0; mem_result = 0;
    wb_rd = 0; wb_reg_write = 0; wb_result = 0;
    model_step();
    @(posedge clk); #1;

    // Reset
    tick(); tick();
    cmp("rst ex_valid", {31'b0, ex_valid}, 32'd0);
    cmp("rst ex_srcA", ex_srcA, 32'd0);
    cmp("rst ex_srcB", ex_srcB, 32'd0);
    cmp("rst ex_ctl", {26'b0, ex_alu_ctrl, ex_reg_write, ex_mem_read, ex_mem_write}, 32'd0);
    cmp("rst id_ready", {31'b0, id_ready}, 32'd1);

    // Plain capture
    rst_n = 1; id_pc = 32'h0FC;
    set_id(1, 5'd1, 32'd5, 5'd0, 32'd0, 5'd4, 32'd7, 1, 3'b000, 1, 0, 0);
    tick();
    cmp("cap srcA", ex_srcA, 32'd5);
    cmp("cap srcB", ex_srcB, 32'd7);
    cmp("cap pc", ex_pc, 32'h100);
    cmp("cap valid", {31'b0, ex_valid}, 32'd1);

    // Forward priority
    set_id(1, 5'd3, 32'd1, 5'd0, 32'd9, 5'd7, 32'd0, 0, 3'b001, 1, 0, 0);
    tick();
    hold = 1;
    mem_rd = 3; mem_reg_write = 1; mem_result = 32'hAA;
    wb_rd = 3; wb_reg_write = 1; wb_result = 32'hBB;
    #1 cmp("fwd mem", ex_srcA, 32'hAA);
    tick();
    mem_reg_write = 0;
    #1 cmp("fwd wb", ex_srcA, 32'hBB);
    tick();
    hold = 0; mem_rd = 0; wb_rd = 0; mem_reg_write = 1; wb_reg_write = 1;
    set_id(1, 5'd0, 32'h77, 5'd0, 32'h0, 5'd8, 32'd0, 0, 3'b010, 1, 0, 0);
    tick();
    hold = 1;
    #1 cmp("fwd x0", ex_srcA, 32'h77);
    tick();
    hold = 0; mem_reg_write = 0; wb_reg_write = 0;

    // Load-use: lw x5, 4(x1) then add x6, x5, x1
    set_id(1, 5'd1, 32'h10, 5'd0, 32'd0, 5'd5, 32'd4, 1, 3'b000, 1, 1, 0);
    tick();
    set_id(1, 5'd5, 32'd0, 5'd1, 32'd3, 5'd6, 32'd0, 0, 3'b000, 1, 0, 0);
    #1 cmp("lu stall", {31'b0, id_ready}, 32'd0);
    tick();
    cmp("lu bubble", {30'b0, ex_valid, ex_reg_write}, 32'd0);
    mem_rd = 5; mem_reg_write = 1; mem_result = 32'h55;
    #1 cmp("lu release", {31'b0, id_ready}, 32'd1);
    tick();
    cmp("lu srcA", ex_srcA, 32'h55);
    cmp("lu srcB", ex_srcB, 32'd3);
    mem_reg_write = 0;

    // WB bypass at capture
    set_id(1, 5'd2, 32'd0, 5'd0, 32'd0, 5'd9, 32'd0, 0, 3'b011, 1, 0, 0);
    wb_rd = 2; wb_reg_write = 1; wb_result = 32'h1234;
    tick();
    wb_reg_write = 0; hold = 1;
    #1 cmp("wb bypass", ex_srcA, 32'h1234);
    tick();
    hold = 0;

    // Flush, then flush together with a load-use hazard
    flush = 1;
    set_id(1, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 32'd0, 0, 3'b000, 1, 0, 0);
    tick();
    cmp("flush valid", {31'b0, ex_valid}, 32'd0);
    flush = 0;
    set_id(1, 5'd1, 32'h20, 5'd0, 32'd0, 5'd4, 32'd0, 1, 3'b000, 1, 1, 0);
    tick();
    set_id(1, 5'd3, 32'd0, 5'd4, 32'd0, 5'd6, 32'd0, 0, 3'b000, 0, 0, 1);
    flush = 1;
    tick();
    flush = 0;

    // Hold for 3 cycles, including a flush that hold must override
    set_id(1, 5'd1, 32'h42, 5'd2, 32'h43, 5'd10, 32'h8, 0, 3'b101, 1, 0, 0);
    tick();
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'd7, $urandom, 5'd8, $urandom, 5'd11, $urandom, 0, 3'b010, 1, 0, 0);
      flush = (i == 1);
      #1 cmp("hold ready", {31'b0, id_ready}, 32'd0);
      tick();
      cmp("hold srcA", ex_srcA, 32'h42);
      cmp("hold ctrl", {29'b0, ex_alu_ctrl}, 32'd5);
    end
    flush = 0;

    // Reset mid-hold
    rst_n = 0;
    tick();
    cmp("rst hold valid", {31'b0, ex_valid}, 32'd0);
    rst_n = 1; hold = 0;

    // Mixed directed sweep over a small register set
    for (int i = 0; i < 40; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), $urandom,
             5'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 3)), $urandom,
             1'($urandom), 3'($urandom_range(0, 5)), 1'($urandom), 1'($urandom), 1'($urandom));
      hold = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      mem_rd = 5'($urandom_range(0, 3)); mem_reg_write = 1'($urandom); mem_result = $urandom;
      wb_rd = 5'($urandom_range(0, 3)); wb_reg_write = 1'($urandom); wb_result = $urandom;
      tick();
    end
    @(negedge clk);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline stage of the rv32i core, directly upstream of the ALU. It registers decoded instruction fields and resolves EX/MEM and MEM/WB forwarding to produce the ALU operands and the 3-bit ALU control. It also detects load-use hazards and stalls the decode stage for one cycle while inserting a bubble. It handles flush on branch redirect and a global pipeline hold.

## Interface
Parameters:
- XLEN, 32, datapath width
- RW, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  decode slot holds an instruction
- id_ready  out  1  stage accepts decode slot this cycle
- id_pc  in  XLEN  instruction PC
- id_rs1, id_rs2, id_rd  in  RW  register addresses
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_alu_src  in  1  0: srcB = rs2, 1: srcB = imm
- id_alu_ctrl  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 eq, 101 slt
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- flush  in  1  branch redirect; kill the instruction being captured
- hold  in  1  global freeze; the whole pipeline stalls
- mem_rd  in  RW; mem_reg_write  in  1; mem_result  in  XLEN  EX/MEM forward source
- wb_rd  in  RW; wb_reg_write  in  1; wb_result  in  XLEN  MEM/WB forward source
- ex_valid  out  1  EX slot holds a live instruction
- ex_srcA, ex_srcB  out  XLEN  ALU operands after forwarding
- ex_alu_ctrl  out  3  to ALU
- ex_store_data  out  XLEN  forwarded rs2 value, for stores
- ex_pc  out  XLEN; ex_rd  out  RW; ex_reg_write, ex_mem_read, ex_mem_write  out  1

## Operation
- Registered state:
  - valid
  - pc, rs1, rs2, rd, rs1_data, rs2_data, imm
  - alu_src, alu_ctrl
  - reg_write, mem_read, mem_write
- Load-use hazard:
  - Fires when ex_valid & ex_mem_read & ex_rd != 0 & id_valid.
  - It also requires ex_rd == id_rs1, or ex_rd == id_rs2 with rs2 used. rs2 is used when id_alu_src = 0 or id_mem_write = 1.
- id_ready = !hold & !hazard.
- Next-state priority per edge:
  1. rst_n = 0 → all regs 0.
  2. hold = 1 → all regs keep their value.
  3. flush = 1 → valid ← 0 and all control bits ← 0.
  4. hazard → bubble: valid ← 0, control bits ← 0; the decode slot is not consumed.
  5. Otherwise → capture the id_* fields; valid ← id_valid; control bits ← id_* & id_valid.
- Capture-time WB bypass: if wb_reg_write & wb_rd != 0 & wb_rd == id_rs1, store wb_result instead of id_rs1_data. The same rule applies to rs2. This covers the same-cycle register-file write.
- EX forwarding is combinational from the registered state. For operand X with registered address rsX:
  - If mem_reg_write & mem_rd != 0 & mem_rd == rsX → mem_result.
  - Else if wb_reg_write & wb_rd != 0 & wb_rd == rsX → wb_result.
  - Else → the registered data.
  - EX/MEM has priority over MEM/WB.
- Operand selection:
  - ex_srcA = forwarded rs1.
  - ex_store_data = forwarded rs2.
  - ex_srcB = imm if alu_src else forwarded rs2.
- Register x0 never forwards and never matches in hazard detection.
- When valid = 0, the control outputs (ex_reg_write, ex_mem_read, ex_mem_write) are 0. ex_alu_ctrl is 000.

## Timing
- Latency: an instruction accepted at edge N is presented on ex_* outputs from N until the next capture.
- Reset (rst_n low at an edge): all ex_* outputs are 0. ex_valid = 0, ex_alu_ctrl = 000. id_ready reflects only hold until a valid load enters EX.
- Load-use: exactly one bubble cycle. At the next edge the load has left EX, the hazard clears, and the dependent instruction is captured; its operand is then supplied by the EX/MEM forward.
- Flush together with hazard: flush wins, and the result is a single bubble. The decode slot's fate belongs to the fetch/decode flush.
- Hold together with flush: hold wins; the flush must be reasserted once hold deasserts.
- Reset mid-stall or mid-hold: the state clears on that edge.

## Test plan
- Reset: drive rst_n = 0 for 2 cycles with random id_* inputs → all ex_* = 0, ex_valid = 0.
- Plain capture: id_rs1_data = 5, id_imm = 7, id_alu_src = 1, ctrl = 000, no forwards → next cycle ex_srcA = 5, ex_srcB = 7, ex_alu_ctrl = 000.
- Forward priority: registered rs1 = x3 with data 1; mem_rd = 3 with mem_result = 0xAA; wb_rd = 3 with wb_result = 0xBB → ex_srcA = 0xAA. With mem_reg_write = 0 → ex_srcA = 0xBB. With x0 → ex_srcA = the registered data.
- Load-use: lw x5 in EX, then add x6, x5, x1 in ID → id_ready = 0 for one cycle and a bubble with ex_reg_write = 0. The next cycle captures the add, and mem_result (rd = 5) appears on ex_srcA.
- WB bypass at capture: wb writes x2 = 0x1234 in the same cycle that ID reads x2 with stale data 0 → the registered rs1_data is 0x1234.
- Flush/hold: flush = 1 with id_valid = 1 → ex_valid = 0 next cycle. hold = 1 for 3 cycles → ex_* outputs unchanged and id_ready = 0 throughout.
